// File: rtl/alu_cmp_pipe.sv
// alu_cmp_pipe: two-stage ALU/compare pipeline with a valid/ready handshake and flush.
// Optional sticky {Z,N,C,V} flags are built only when ALU_CMP_FLAGS_EN is defined.
module alu_cmp_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    instr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             sign,
  output logic             ovf,
  output logic [3:0]       flags,
  input  logic             flag_clr
);

  localparam int unsigned Msb = WIDTH - 1;

  typedef enum logic [2:0] {
    OpNone, OpAdd, OpSub, OpSeq, OpSlt, OpSle, OpSco, OpLtu
  } op_e;

  logic [4:0] opcode;
  logic [1:0] func;
  logic       unused_instr;

  assign opcode       = instr[IW-1:IW-5];
  assign func         = instr[1:0];
  assign unused_instr = ^instr[IW-6:2];

  op_e  dec_op;
  logic dec_sign;

  always_comb begin
    dec_op   = OpNone;
    dec_sign = 1'b0;
    casez (opcode)
      5'b01000: begin dec_op = OpAdd; dec_sign = 1'b1; end
      5'b01001: begin dec_op = OpSub; dec_sign = 1'b1; end
      5'b100??: begin
        dec_sign = (opcode[1:0] != 2'b10);
        if (opcode[1:0] == 2'b11) dec_op = OpLtu;
      end
      5'b11011: begin
        dec_sign = ~func[1];
        if (func == 2'b00)      dec_op = OpAdd;
        else if (func == 2'b01) dec_op = OpSub;
      end
      5'b111??: begin
        dec_sign = (opcode[1:0] != 2'b11);
        case (opcode[1:0])
          2'b00:   dec_op = OpSeq;
          2'b01:   dec_op = OpSlt;
          2'b10:   dec_op = OpSle;
          default: dec_op = OpSco;
        endcase
      end
      default: ;
    endcase
  end

  logic             s1_valid_q, s2_valid_q;
  op_e              s1_op_q;
  logic             s1_sign_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [WIDTH-1:0] result_q;
  logic             sign_q, ovf_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  always_comb begin
    sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff    = s1_a_q - s1_b_q;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (s1_op_q)
      OpAdd: begin
        alu_res = sum[Msb:0];
        alu_ovf = (s1_a_q[Msb] == s1_b_q[Msb]) && (sum[Msb] != s1_a_q[Msb]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (s1_a_q[Msb] != s1_b_q[Msb]) && (diff[Msb] != s1_a_q[Msb]);
      end
      OpSeq: alu_res = {{Msb{1'b0}}, (s1_a_q == s1_b_q)};
      OpSlt: alu_res = {{Msb{1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      OpSle: alu_res = {{Msb{1'b0}}, ($signed(s1_a_q) <= $signed(s1_b_q))};
      OpSco: begin
        alu_res = {{Msb{1'b0}}, sum[WIDTH]};
        alu_ovf = sum[WIDTH];
      end
      OpLtu: alu_res = {{Msb{1'b0}}, (s1_a_q < s1_b_q)};
      default: ;
    endcase
  end

  logic s2_en;

  // S2 can take new data when it is empty or its current result leaves this cycle.
  assign s2_en     = ~s2_valid_q | out_ready;
  assign in_ready  = rst_n & (~s1_valid_q | s2_en);
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign sign      = sign_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_op_q    <= OpNone;
      s1_sign_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      result_q   <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q <= alu_res;
          sign_q   <= s1_sign_q;
          ovf_q    <= alu_ovf;
        end
      end
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_op_q   <= dec_op;
          s1_sign_q <= dec_sign;
          s1_a_q    <= a;
          s1_b_q    <= b;
        end
      end
    end
  end

`ifdef ALU_CMP_FLAGS_EN
  logic [3:0] flags_q, flag_bits;
  logic       out_hs;

  // A flushed output is not a delivered result, so it does not touch the flags.
  assign out_hs    = s2_valid_q & out_ready & ~flush;
  assign flag_bits = {(result_q == '0), result_q[Msb], ovf_q & ~sign_q, ovf_q & sign_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flag_clr) begin
      flags_q <= out_hs ? flag_bits : 4'b0000;
    end else if (out_hs) begin
      flags_q <= flags_q | flag_bits;
    end
  end

  assign flags = flags_q;
`else
  logic unused_flag_clr;

  assign unused_flag_clr = flag_clr;
  assign flags           = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Self-checking bench for alu_cmp_pipe: directed cases plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_alu_cmp_pipe;

  localparam int W   = 16;
  localparam int IWD = 16;
`ifdef ALU_CMP_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           flush = 1'b0;
  logic           out_ready = 1'b0;
  logic           flag_clr = 1'b0;
  logic [IWD-1:0] instr = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready, out_valid, sign, ovf;
  logic [W-1:0]   result;
  logic [3:0]     flags;

  alu_cmp_pipe #(.WIDTH(W), .IW(IWD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sign      (sign),
    .ovf       (ovf),
    .flags     (flags),
    .flag_clr  (flag_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    bit           sgn;
    bit           ovf;
    int           edge_no;
  } txn_t;

  txn_t         q[$];
  logic [W-1:0] obs[$];
  int           edges = 0;
  logic [3:0]   mflags = 4'b0000;
  int           checks = 0;
  int           failures = 0;
  bit           last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    int u;
    u = int'({16'b0, v});
    return v[W-1] ? u - 65536 : u;
  endfunction

  function automatic logic [IWD-1:0] mk(input logic [4:0] op, input logic [1:0] fn);
    return {op, 9'b0, fn};
  endfunction

  // Reference: what a single instruction must produce, from plain integer arithmetic.
  function automatic txn_t ref_calc(input logic [IWD-1:0] ins, input logic [W-1:0] x,
                                    input logic [W-1:0] y);
    txn_t t;
    int   op, fn, ux, uy, r;
    op = int'({27'b0, ins[IWD-1:IWD-5]});
    fn = int'({30'b0, ins[1:0]});
    ux = int'({16'b0, x});
    uy = int'({16'b0, y});
    t.res     = '0;
    t.ovf     = 1'b0;
    t.edge_no = 0;
    t.sgn = (op == 8) || (op == 9) || (op >= 16 && op <= 19 && op != 18) ||
            (op == 27 && fn < 2) || (op >= 28 && op != 31);
    if (op == 8 || (op == 27 && fn == 0)) begin
      r = sx(x) + sx(y);
      t.res = W'(ux + uy);
      t.ovf = (r > 32767) || (r < -32768);
    end else if (op == 9 || (op == 27 && fn == 1)) begin
      r = sx(x) - sx(y);
      t.res = W'(ux - uy);
      t.ovf = (r > 32767) || (r < -32768);
    end else if (op == 28) begin
      t.res = (x == y) ? W'(1) : W'(0);
    end else if (op == 29) begin
      t.res = (sx(x) < sx(y)) ? W'(1) : W'(0);
    end else if (op == 30) begin
      t.res = (sx(x) <= sx(y)) ? W'(1) : W'(0);
    end else if (op == 31) begin
      t.ovf = (ux + uy) > 65535;
      t.res = t.ovf ? W'(1) : W'(0);
    end else if (op == 19) begin
      t.res = (ux < uy) ? W'(1) : W'(0);
    end
    return t;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock cycle: compare at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit           exp_ready, exp_valid, acc, hs;
    logic [3:0]   bits;
    logic [W-1:0] res_s;
    txn_t         t;
    bits = 4'b0000;
    @(negedge clk);
    exp_ready = (q.size() < 2) || out_ready;
    exp_valid = (q.size() > 0) && (edges >= q[0].edge_no + 1);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      chk("result", result, q[0].res);
      chk("sign", sign, q[0].sgn);
      chk("ovf", ovf, q[0].ovf);
      bits = {(q[0].res == '0), q[0].res[W-1], q[0].ovf && !q[0].sgn, q[0].ovf && q[0].sgn};
    end
    chk("flags", flags, FlagsEn ? mflags : 4'b0000);
    res_s    = result;
    acc      = in_valid && exp_ready && !flush;
    hs       = exp_valid && out_ready && !flush;
    last_acc = acc;
    @(posedge clk);
    edges++;
    if (flush) begin
      q.delete();
    end else begin
      if (hs) begin
        obs.push_back(res_s);
        void'(q.pop_front());
      end
      if (acc) begin
        t = ref_calc(instr, a, b);
        t.edge_no = edges;
        q.push_back(t);
      end
    end
    if (FlagsEn) begin
      if (flag_clr) mflags = hs ? bits : 4'b0000;
      else if (hs)  mflags = mflags | bits;
    end
    #1;
  endtask

  initial begin
    txn_t t;
    int   seen;
    int   cyc;
    int   i;

    // Reset state while rst_n is held low.
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sign", sign, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_flags", flags, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model with hand-computed values.
    t = ref_calc(mk(5'b11011, 2'b00), 16'h7FFF, 16'h0001);
    chk("model_add", {t.res, 14'b0, t.sgn, t.ovf}, {16'h8000, 14'b0, 1'b1, 1'b1});
    t = ref_calc(mk(5'b10011, 2'b00), 16'hFFFF, 16'h0001);
    chk("model_ltu", {t.res, 14'b0, t.sgn, t.ovf}, {16'h0000, 14'b0, 1'b1, 1'b0});
    t = ref_calc(mk(5'b11111, 2'b00), 16'hFFFF, 16'h0001);
    chk("model_sco", {t.res, 14'b0, t.sgn, t.ovf}, {16'h0001, 14'b0, 1'b0, 1'b1});

    // Signed overflow on ADD, two-cycle latency.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = mk(5'b11011, 2'b00);
    a = 16'h7FFF; b = 16'h0001;
    step();
    in_valid = 1'b0;
    step();
    chk("add_valid", out_valid, 1);
    chk("add_res", result, 16'h8000);
    chk("add_sign", sign, 1);
    chk("add_ovf", ovf, 1);
    step();
    chk("add_flags", flags, FlagsEn ? 4'b0101 : 4'b0000);

    // SLT vs LTU on the same operands.
    flag_clr = 1'b1;
    in_valid = 1'b1;
    instr = mk(5'b11101, 2'b00); a = 16'hFFFF; b = 16'h0001;
    step();
    flag_clr = 1'b0;
    instr = mk(5'b10011, 2'b00);
    step();
    in_valid = 1'b0;
    chk("slt_res", result, 1);
    chk("slt_sign", sign, 1);
    step();
    chk("ltu_res", result, 0);
    chk("ltu_sign", sign, 1);
    step();

    // Carry-out compare.
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    in_valid = 1'b1;
    instr = mk(5'b11111, 2'b00); a = 16'hFFFF; b = 16'h0001;
    step();
    in_valid = 1'b0;
    step();
    chk("sco_res", result, 1);
    chk("sco_ovf", ovf, 1);
    chk("sco_sign", sign, 0);
    step();
    chk("sco_flags", flags, FlagsEn ? 4'b0010 : 4'b0000);

    // Four back-to-back SUBs with the consumer stalled for three cycles.
    obs.delete();
    i = 0;
    cyc = 0;
    while (i < 4 && cyc < 20) begin
      in_valid  = 1'b1;
      instr     = mk(5'b11011, 2'b01);
      a         = W'(100 + i);
      b         = W'(3 * i);
      out_ready = (cyc >= 3);
      step();
      if (cyc == 1) chk("stall_in_ready", in_ready, 0);
      if (last_acc) i++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() > 0; k++) step();
    chk("sub_drained", q.size(), 0);
    chk("sub_count", obs.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < obs.size()) chk("sub_order", obs[k], W'(100 - 2 * k));

    // Flush with both stages full and a third input offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = mk(5'b01000, 2'b00);
    a = 16'h0010; b = 16'h0001;
    step();
    a = 16'h0020;
    step();
    chk("fill_out_valid", out_valid, 1);
    chk("fill_in_ready", in_ready, 0);
    flush = 1'b1;
    a = 16'h0030;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      step();
      if (out_valid) seen++;
    end
    chk("flush_no_output", seen, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] op;
      case ($urandom_range(0, 9))
        0: op = 5'b01000;
        1: op = 5'b01001;
        2: op = 5'b10011;
        3: op = 5'b11011;
        4: op = 5'b11100;
        5: op = 5'b11101;
        6: op = 5'b11110;
        7: op = 5'b11111;
        default: op = 5'($urandom_range(0, 31));
      endcase
      instr     = mk(op, 2'($urandom_range(0, 3)));
      instr[9:4] = 6'($urandom);
      a         = pick();
      b         = pick();
      in_valid  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
      flag_clr  = ($urandom_range(0, 19) == 0);
      step();
    end
    flush    = 1'b0;
    flag_clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() > 0; k++) step();
    chk("rand_drained", q.size(), 0);

    // Asynchronous reset between edges with a result waiting.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = mk(5'b11011, 2'b00); a = 16'h4000; b = 16'h4000;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_out_valid", out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_flags", flags, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_result", result, 0);
    q.delete();
    mflags = 4'b0000;
    #2 rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr = mk(5'b11100, 2'b00); a = 16'h1234; b = 16'h1234;
    step();
    in_valid = 1'b0;
    step();
    chk("seq_valid", out_valid, 1);
    chk("seq_res", result, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
